mem_wait_model: RTL and testbench

Parametrised, word-addressed memory model with a request/ready handshake, configurable wait states, byte-lane write masking and out-of-range error reporting. Next-generation replacement for the zero-wait text/data/stack memories in the CPU test environment. Each instance maps `WORD_DEPTH` words at a run-time base address. A multicycle or pipelined CHIP holds its request until `ready` and stalls in between.

---
 rtl/mem_wait_model.sv | 184 ++++++++++++++++++
 tb/tb_mem_wait_model.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wait_model.sv
// mem_wait_model
//   Word-addressed memory model with a req/ready handshake and a fixed
//   number of wait states. The model maps WORD_DEPTH words starting at
//   byte address `offset`. It supports byte-lane write masking and flags
//   accesses that fall outside its window or are not word-aligned.
//
// Ports
//   clk     : clock, rising edge active
//   rst_n   : asynchronous active-low reset. Clears memory, outputs and FSM.
//   offset  : base byte address of word 0 (static while out of reset)
//   req     : access request, sampled only in IDLE
//   wen     : 1 = write, 0 = read
//   addr    : byte address of the access
//   wdata   : write data
//   wmask   : byte-lane write enables (bit i -> wdata[8i+7:8i])
//   rdata   : registered read data (pre-write contents on a write, 0 on error)
//   ready   : registered one-cycle completion pulse
//   err     : the completed access was illegal (qualified by ready)
//
// FSM
//   state  | meaning
//   IDLE   | waiting for req; on req latch the request and load the timer
//   BUSY   | wait states; timer counts down, access performed at zero
//   DONE   | ready pulse for one cycle, then back to IDLE
module mem_wait_model #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int WORD_DEPTH = 64,
  parameter int LATENCY    = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   offset,
  input  logic                req,
  input  logic                wen,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wmask,
  output logic [DATA_W-1:0]   rdata,
  output logic                ready,
  output logic                err
);

  localparam int NB    = DATA_W / 8;
  localparam int LSB   = (NB > 1) ? $clog2(NB) : 0;
  localparam int IDX_W = (WORD_DEPTH > 1) ? $clog2(WORD_DEPTH) : 1;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic                cnt_load;
  logic                cnt_dec;
  logic                do_access;

  // Request captured at acceptance; everything downstream uses these.
  logic                a_wen;
  logic [ADDR_W-1:0]   a_addr;
  logic [DATA_W-1:0]   a_wdata;
  logic [NB-1:0]       a_wmask;

  logic [DATA_W-1:0]   mem [WORD_DEPTH];

  // Address decode
  logic [ADDR_W-1:0]   diff;
  logic [ADDR_W-1:0]   word_off;
  logic                below;
  logic                misalign;
  logic                beyond;
  logic                illegal;
  logic [IDX_W-1:0]    idx;

  always_comb begin
    diff     = a_addr - offset;
    word_off = diff >> LSB;
    below    = a_addr < offset;
    misalign = (a_addr & ADDR_W'(NB - 1)) != '0;
    // Compare the full shifted offset so large wrap-around values are caught,
    // not just the bits that index the array.
    beyond   = word_off >= ADDR_W'(WORD_DEPTH);
    illegal  = below | misalign | beyond;
    idx      = word_off[IDX_W-1:0];
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    do_access = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) begin
          cnt_load  = 1'b1;
          state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt != '0) begin
          cnt_dec = 1'b1;
        end else begin
          do_access = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Wait-state down-counter; terminal count 0 triggers the access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt_load) begin
      cnt <= CNT_W'(LATENCY - 1);
    end else if (cnt_dec) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_wen   <= 1'b0;
      a_addr  <= '0;
      a_wdata <= '0;
      a_wmask <= '0;
    end else if (cnt_load) begin
      a_wen   <= wen;
      a_addr  <= addr;
      a_wdata <= wdata;
      a_wmask <= wmask;
    end
  end

  // ready is high exactly in DONE, since do_access is only asserted on the
  // final BUSY cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
    end else begin
      ready <= do_access;
      if (do_access) begin
        err   <= illegal;
        rdata <= illegal ? '0 : mem[idx];
      end
    end
  end

  // Storage. rdata above samples the pre-write word on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < WORD_DEPTH; w++) begin
        mem[w] <= '0;
      end
    end else if (do_access && a_wen && !illegal) begin
      for (int b = 0; b < NB; b++) begin
        if (a_wmask[b]) begin
          mem[idx][8*b +: 8] <= a_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_wait_model.sv
module tb_mem_wait_model;

  localparam logic [31:0] OFS = 32'h1001_0000;

  logic        clk;
  logic        rst_n;
  logic [31:0] offset;
  logic        req;
  logic        req1;
  logic        wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic [31:0] rdata;
  logic        ready;
  logic        err;
  logic [31:0] rdata1;
  logic        ready1;
  logic        err1;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  mem_wait_model #(.DATA_W(32), .ADDR_W(32), .WORD_DEPTH(64), .LATENCY(2)) dut (
    .clk(clk), .rst_n(rst_n), .offset(offset), .req(req), .wen(wen),
    .addr(addr), .wdata(wdata), .wmask(wmask),
    .rdata(rdata), .ready(ready), .err(err)
  );

  mem_wait_model #(.DATA_W(32), .ADDR_W(32), .WORD_DEPTH(64), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .offset(offset), .req(req1), .wen(wen),
    .addr(addr), .wdata(wdata), .wmask(wmask),
    .rdata(rdata1), .ready(ready1), .err(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one access on the LATENCY=2 instance. Call at posedge+1 with DUT idle.
  task automatic do_acc(input string tag, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] m,
                        output logic [31:0] rd, output logic e);
    int lat;
    wen = w; addr = a; wdata = d; wmask = m; req = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (!ready && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd2);
    rd = rdata;
    e  = err;
    req = 1'b0;
    @(posedge clk); #1;
    check({tag, "_ready_single"}, {31'd0, ready}, 32'd0);
  endtask

  logic [31:0] rd;
  logic        e;
  int          t[3];
  int          k;
  int          guard;
  int          nrdy;

  initial begin
    rst_n = 1'b1; offset = OFS; req = 1'b0; req1 = 1'b0;
    wen = 1'b0; addr = '0; wdata = '0; wmask = '0;

    // Reset asserted between edges: outputs clear at once.
    #3 rst_n = 1'b0;
    #1;
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_err",   {31'd0, err},   32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_ready1", {31'd0, ready1}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_acc("rd_base", 1'b0, OFS, 32'h0, 4'h0, rd, e);
    check("rd_base_data", rd, 32'h0);
    check("rd_base_err",  {31'd0, e}, 32'd0);

    // Full write and read-back
    do_acc("wr_full", 1'b1, OFS + 32'h8, 32'hDEAD_BEEF, 4'hF, rd, e);
    check("wr_full_old", rd, 32'h0);
    check("wr_full_err", {31'd0, e}, 32'd0);
    do_acc("rd_full", 1'b0, OFS + 32'h8, 32'h0, 4'h0, rd, e);
    check("rd_full_data", rd, 32'hDEAD_BEEF);
    check("rd_full_err",  {31'd0, e}, 32'd0);

    // Masked write, read-before-write
    do_acc("wr_init", 1'b1, OFS + 32'hC, 32'h1122_3344, 4'hF, rd, e);
    do_acc("wr_mask", 1'b1, OFS + 32'hC, 32'hAABB_CCDD, 4'b0101, rd, e);
    check("wr_mask_old", rd, 32'h1122_3344);
    do_acc("rd_mask", 1'b0, OFS + 32'hC, 32'h0, 4'h0, rd, e);
    check("rd_mask_data", rd, 32'h11BB_33DD);

    // Zero mask completes without change
    do_acc("wr_nomask", 1'b1, OFS + 32'hC, 32'hFFFF_FFFF, 4'h0, rd, e);
    check("wr_nomask_err", {31'd0, e}, 32'd0);
    do_acc("rd_nomask", 1'b0, OFS + 32'hC, 32'h0, 4'h0, rd, e);
    check("rd_nomask_data", rd, 32'h11BB_33DD);

    // Illegal accesses
    do_acc("rd_below", 1'b0, 32'h1000_FFFC, 32'h0, 4'h0, rd, e);
    check("rd_below_err",  {31'd0, e}, 32'd1);
    check("rd_below_data", rd, 32'h0);
    do_acc("wr_unal", 1'b1, OFS + 32'h2, 32'hFFFF_FFFF, 4'hF, rd, e);
    check("wr_unal_err",  {31'd0, e}, 32'd1);
    check("wr_unal_data", rd, 32'h0);
    do_acc("rd_w0", 1'b0, OFS, 32'h0, 4'h0, rd, e);
    check("rd_w0_data", rd, 32'h0);
    check("rd_w0_err",  {31'd0, e}, 32'd0);
    do_acc("rd_beyond", 1'b0, OFS + 32'd256, 32'h0, 4'h0, rd, e);
    check("rd_beyond_err", {31'd0, e}, 32'd1);
    do_acc("wr_last", 1'b1, OFS + 32'd252, 32'h5A5A_5A5A, 4'hF, rd, e);
    check("wr_last_err", {31'd0, e}, 32'd0);
    do_acc("rd_last", 1'b0, OFS + 32'd252, 32'h0, 4'h0, rd, e);
    check("rd_last_data", rd, 32'h5A5A_5A5A);
    check("rd_last_err",  {31'd0, e}, 32'd0);

    // req held high across three reads: pulses LATENCY+2 = 4 apart
    wen = 1'b0; addr = OFS + 32'h8; req = 1'b1;
    k = 0;
    for (guard = 0; guard < 40 && k < 3; guard++) begin
      @(posedge clk); #1;
      if (ready) begin
        t[k] = cyc;
        k++;
        check("b2b_data", rdata, 32'hDEAD_BEEF);
        if (k == 3) req = 1'b0;
      end
    end
    req = 1'b0;
    check("b2b_count", 32'(k), 32'd3);
    check("b2b_gap1", 32'(t[1] - t[0]), 32'd4);
    check("b2b_gap2", 32'(t[2] - t[1]), 32'd4);
    @(posedge clk); #1;

    // req toggled while BUSY has no effect
    wen = 1'b0; addr = OFS + 32'hC; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    req = 1'b1;
    @(posedge clk); #1;
    check("tog_ready", {31'd0, ready}, 32'd1);
    check("tog_data", rdata, 32'h11BB_33DD);
    req = 1'b0;
    nrdy = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (ready) nrdy++;
    end
    check("tog_no_extra", 32'(nrdy), 32'd0);
    check("idle_hold_data", rdata, 32'h11BB_33DD);

    // LATENCY=1 instance: pulses 3 apart
    wen = 1'b0; addr = OFS; req1 = 1'b1;
    k = 0;
    for (guard = 0; guard < 40 && k < 3; guard++) begin
      @(posedge clk); #1;
      if (ready1) begin
        t[k] = cyc;
        k++;
        if (k == 3) req1 = 1'b0;
      end
    end
    req1 = 1'b0;
    check("l1_count", 32'(k), 32'd3);
    check("l1_gap1", 32'(t[1] - t[0]), 32'd3);
    check("l1_gap2", 32'(t[2] - t[1]), 32'd3);
    check("l1_err", {31'd0, err1}, 32'd0);
    @(posedge clk); #1;

    // Reset during BUSY aborts the write
    wen = 1'b1; addr = OFS + 32'h1C; wdata = 32'h1234_5678; wmask = 4'hF; req = 1'b1;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_rdata", rdata, 32'h0);
    check("mid_rst_ready", {31'd0, ready}, 32'd0);
    req = 1'b0;
    nrdy = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (ready) nrdy++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (ready) nrdy++;
    end
    check("mid_rst_no_ready", 32'(nrdy), 32'd0);
    do_acc("rd_aborted", 1'b0, OFS + 32'h1C, 32'h0, 4'h0, rd, e);
    check("rd_aborted_data", rd, 32'h0);
    do_acc("rd_cleared", 1'b0, OFS + 32'h8, 32'h0, 4'h0, rd, e);
    check("rd_cleared_data", rd, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
